// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: Moore FSM that sequences SPARC loads/stores through MAR/MDR and the ram512x8 MFC handshake.
// Optional MFC timeout fault is compiled in when MEM_TIMEOUT_EN is defined.
module mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       start,
    input  logic [5:0] op3,
    input  logic [2:0] addr_lsb,
    input  logic       MFC,
    output logic       busy,
    output logic       done,
    output logic       trap_align,
    output logic       trap_illegal,
    output logic       trap_timeout,
    output logic       alu_phase,
    output logic       MAR_Enable,
    output logic       MDR_Enable,
    output logic       MDR_Mux_select,
    output logic       RAM_enable,
    output logic [5:0] RAM_OpCode
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ACCESS,
        S_CAPTURE,
        S_DONE,
        S_FAULT_ALIGN,
        S_FAULT_ILLEGAL,
        S_FAULT_TIMEOUT
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [5:0] op_q;
    logic       is_store;
    logic       misaligned;
    logic       unused_addr_bit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010,
            6'b000100, 6'b000101, 6'b000110: op_legal = 1'b1;
            default:                         op_legal = 1'b0;
        endcase
    endfunction

    // Size lives in op_q[1:0]: 00 word, 01 byte, 10 half; bytes are always aligned.
    assign is_store        = op_q[2];
    assign misaligned      = ((op_q[1:0] == 2'b00) && (addr_lsb[1:0] != 2'b00)) ||
                             ((op_q[1:0] == 2'b10) && addr_lsb[0]);
    assign unused_addr_bit = addr_lsb[2];

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                op_q <= op3;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Held at zero outside ACCESS, so it is clear on every entry.
    always_ff @(posedge Clk) begin
        if (!Clr || state != S_ACCESS) begin
            wait_cnt <= '0;
        end else if (!MFC) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // NOTE: every output and state_nx gets a default first so no latch is inferred.
    always_comb begin
        state_nx       = state;
        busy           = (state != S_IDLE);
        done           = 1'b0;
        trap_align     = 1'b0;
        trap_illegal   = 1'b0;
        trap_timeout   = 1'b0;
        alu_phase      = 1'b0;
        MAR_Enable     = 1'b0;
        MDR_Enable     = 1'b0;
        MDR_Mux_select = 1'b0;
        RAM_enable     = 1'b0;
        RAM_OpCode     = (state != S_IDLE) ? op_q : 6'b000000;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = op_legal(op3) ? S_ADDR : S_FAULT_ILLEGAL;
                end
            end
            S_ADDR: begin
                MAR_Enable = 1'b1;
                if (misaligned)    state_nx = S_FAULT_ALIGN;
                else if (is_store) state_nx = S_DATA;
                else               state_nx = S_ACCESS;
            end
            S_DATA: begin
                MDR_Enable = 1'b1;
                alu_phase  = 1'b1;
                state_nx   = S_ACCESS;
            end
            S_ACCESS: begin
                RAM_enable = 1'b1;
                // MFC is tested first so a completion on the limit cycle still succeeds.
                if (MFC) begin
                    state_nx = is_store ? S_DONE : S_CAPTURE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nx = S_FAULT_TIMEOUT;
                end
`endif
            end
            S_CAPTURE: begin
                RAM_enable     = 1'b1;
                MDR_Enable     = 1'b1;
                MDR_Mux_select = 1'b1;
                state_nx       = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_FAULT_ALIGN: begin
                done       = 1'b1;
                trap_align = 1'b1;
                state_nx   = S_IDLE;
            end
            S_FAULT_ILLEGAL: begin
                done         = 1'b1;
                trap_illegal = 1'b1;
                state_nx     = S_IDLE;
            end
            S_FAULT_TIMEOUT: begin
                done = 1'b1;
`ifdef MEM_TIMEOUT_EN
                trap_timeout = 1'b1;
`endif
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
